fw_cfg_shift_ctrl: RTL
======================

FW_CFG_SHIFT_CTRL -- requirements
Module: fw_cfg_shift_ctrl

Interface
REQ-001 Parameter: CLK_HALF_W, default 8, width of clk_half.
REQ-002 fw_clk  in  1  FW clock; all logic on rising edge.
REQ-003 fw_rst  in  1  asynchronous, active-high reset.
REQ-004 start  in  1  single-cycle request to begin a shift sequence.
REQ-005 abort  in  1  single-cycle request to terminate the sequence in progress.
REQ-006 bit_count  in  16  number of config bits to shift; sampled at accepted start.
REQ-007 clk_half  in  CLK_HALF_W  fw_config_clk half-period in fw_clk cycles; sampled at accepted start; 0 treated as 1.
REQ-008 wr_data  in  32  next config word, shifted MSB first.
REQ-009 wr_valid / wr_ready  in / out  1 each  word handshake; transfer when both are high.
REQ-010 rd_data  out  32  captured fw_config_out word, MSB = first bit captured.
REQ-011 rd_valid  out  1  one-cycle strobe qualifying rd_data; no backpressure.
REQ-012 fw_config_clk, fw_config_in, fw_config_load  out  1 each  DUT config chain drive.
REQ-013 fw_config_out  in  1  DUT config chain serial return.
REQ-014 busy  out  1  high in any state other than IDLE.
REQ-015 done  out  1  one-cycle strobe at normal completion.
REQ-016 err_len  out  1  sticky; set when start is accepted with bit_count = 0.

Function
REQ-017 States SHALL be IDLE, FETCH, SHIFT_LO, SHIFT_HI, LOAD, DONE.
REQ-018 In IDLE with start=1 and bit_count>0, the FSM SHALL go to FETCH next cycle and clear err_len.
REQ-019 In IDLE with start=1 and bit_count=0, the FSM SHALL set err_len and stay in IDLE; no done.
REQ-020 start SHALL be ignored when not in IDLE.
REQ-021 wr_ready SHALL be high only in FETCH; a transfer loads the 32-bit shift register and moves to SHIFT_LO.
REQ-022 FETCH without wr_valid SHALL stall with fw_config_clk held low; no timeout, no error.
REQ-023 On entry to SHIFT_LO, fw_config_in SHALL present the current MSB; fw_config_clk is low for clk_half cycles.
REQ-024 SHIFT_HI SHALL drive fw_config_clk high for clk_half cycles.
REQ-025 fw_config_out SHALL be sampled on the fw_clk edge where fw_config_clk rises.
REQ-026 At the end of SHIFT_HI, the remaining-bit counter SHALL decrement and route the FSM as follows.
  - Counter reaches 0: go to LOAD.
  - 32 bits of the word used: go to FETCH.
  - Otherwise: go to SHIFT_LO with the next bit.
REQ-027 A 16-bit counter SHALL track remaining bits; bits of a final word beyond bit_count are discarded.
REQ-028 rd_valid SHALL pulse one cycle after every 32nd capture.
REQ-029 At completion with a partial capture of n<32 bits, the capture word SHALL be emitted left-aligned with LSB zero-pad; rd_valid one cycle after the last capture.
REQ-030 LOAD SHALL drive fw_config_load low for 2*clk_half cycles with fw_config_clk low, then go to DONE.
REQ-031 DONE SHALL assert done for one cycle and return to IDLE.
REQ-032 abort in any non-IDLE state SHALL return the FSM to IDLE next cycle.
  - fw_config_clk low, fw_config_load high.
  - No done, no LOAD pulse, no rd_valid for the partial word.
REQ-033 abort in the same cycle as start in IDLE: abort wins; FSM stays IDLE.
REQ-034 Idle levels SHALL be fw_config_clk=0, fw_config_in=0, fw_config_load=1.
REQ-035 All DUT-facing outputs SHALL be registered (glitch-free).

Reset
REQ-036 fw_rst=1 SHALL immediately force the following, without waiting for a clock edge.
  - State IDLE.
  - fw_config_clk=0, fw_config_in=0, fw_config_load=1.
  - wr_ready=0, rd_valid=0, rd_data=0, busy=0, done=0, err_len=0.
  - Counters and shift registers cleared.
REQ-037 Reset asserted mid-sequence SHALL behave as REQ-036; a new start is accepted on the first edge after release.

Verification
REQ-038 bit_count=8, clk_half=2, word 0xA5000000 -> fw_config_in 1,0,1,0,0,1,0,1 on 8 rising edges, each 4 fw_clk apart; fw_config_load low 4 cycles; one done.
REQ-039 bit_count=40, loopback fw_config_out=fw_config_in, words 0x12345678, 0xFF000000 -> rd_data 0x12345678 then 0xFF000000; two rd_valid; wr_ready seen twice.
REQ-040 bit_count=32, wr_valid withheld 10 cycles in FETCH -> fw_config_clk stays 0, busy=1; sequence resumes on wr_valid.
REQ-041 abort after 5 rising edges of a 16-bit sequence -> IDLE next cycle; fw_config_load never low; no done, no rd_valid.
REQ-042 start with bit_count=0 -> err_len=1, busy stays 0; next valid start clears err_len.
REQ-043 clk_half=0 -> behaves as clk_half=1; fw_rst pulse mid-SHIFT_HI -> outputs at idle levels within the same cycle.

Source files
------------

// File: rtl/fw_cfg_shift_ctrl.sv
// fw_cfg_shift_ctrl: serial configuration-chain driver.
// Fetches 32-bit words over a valid/ready handshake and shifts them out MSB first
// on fw_config_in / fw_config_clk. It captures fw_config_out on each rising
// fw_config_clk and finishes with a low fw_config_load pulse and a done strobe.
module fw_cfg_shift_ctrl #(
  parameter int CLK_HALF_W = 8
) (
  input  logic                  fw_clk,
  input  logic                  fw_rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [15:0]           bit_count,
  input  logic [CLK_HALF_W-1:0] clk_half,
  input  logic [31:0]           wr_data,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  output logic [31:0]           rd_data,
  output logic                  rd_valid,
  output logic                  fw_config_clk,
  output logic                  fw_config_in,
  output logic                  fw_config_load,
  input  logic                  fw_config_out,
  output logic                  busy,
  output logic                  done,
  output logic                  err_len
);

  // The timer needs one extra bit so that it can hold the LOAD length of 2*clk_half.
  localparam int TW = CLK_HALF_W + 1;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    SHIFT_LO,
    SHIFT_HI,
    LOAD,
    DONE
  } state_t;

  state_t                state;
  logic [CLK_HALF_W-1:0] half_q;      // clk_half latched at start, never 0
  logic [TW-1:0]         timer;       // cycles left in the current phase, minus one
  logic [15:0]           bits_left;   // config bits still to shift
  logic [4:0]            bit_idx;     // bit position within the current word
  logic [31:0]           shift_reg;   // outgoing word, MSB is the current bit
  logic [31:0]           cap_reg;     // incoming bits, newest in the LSB
  logic [5:0]            cap_cnt;     // bits in cap_reg since the last emitted word
  logic                  pend_valid;  // a captured word goes out on the next edge
  logic                  pend_full;   // the pending word is a full 32-bit word
  logic [31:0]           pend_data;

  logic [CLK_HALF_W-1:0] half_eff;
  logic [TW-1:0]         half_m1;
  logic [TW-1:0]         load_m1;
  logic [31:0]           cap_next;
  logic [5:0]            cnt_next;
  logic                  cap_last;
  logic [31:0]           cap_aligned;

  // Phase lengths, next capture word, and the left-aligned form of a partial final word.
  assign half_eff    = (clk_half == '0) ? CLK_HALF_W'(1) : clk_half;
  assign half_m1     = {1'b0, half_q} - TW'(1);
  assign load_m1     = {half_q, 1'b0} - TW'(1);
  assign cap_next    = {cap_reg[30:0], fw_config_out};
  assign cnt_next    = cap_cnt + 6'd1;
  assign cap_last    = (cnt_next == 6'd32) || (bits_left == 16'd1);
  assign cap_aligned = cap_next << (6'd32 - cnt_next);

  // Handshake and status flags decode directly from the state register.
  assign wr_ready = (state == FETCH);
  assign busy     = (state != IDLE);

  // Main sequencer: state, chain drive, capture path and strobes.
  always_ff @(posedge fw_clk or posedge fw_rst) begin
    if (fw_rst) begin
      state          <= IDLE;
      half_q         <= CLK_HALF_W'(1);
      timer          <= '0;
      bits_left      <= '0;
      bit_idx        <= '0;
      shift_reg      <= '0;
      cap_reg        <= '0;
      cap_cnt        <= '0;
      pend_valid     <= 1'b0;
      pend_full      <= 1'b0;
      pend_data      <= '0;
      rd_data        <= '0;
      rd_valid       <= 1'b0;
      fw_config_clk  <= 1'b0;
      fw_config_in   <= 1'b0;
      fw_config_load <= 1'b1;
      done           <= 1'b0;
      err_len        <= 1'b0;
    end else begin
      // NOTE: non-blocking defaults first; any later assignment in this block
      // overrides them, so the strobes last exactly one cycle.
      rd_valid   <= 1'b0;
      done       <= 1'b0;
      pend_valid <= 1'b0;

      // A partial word that is still pending is dropped when the sequence is aborted.
      if (pend_valid && (pend_full || !(abort && state != IDLE))) begin
        rd_data  <= pend_data;
        rd_valid <= 1'b1;
      end

      if (abort && state != IDLE) begin
        state          <= IDLE;
        fw_config_clk  <= 1'b0;
        fw_config_in   <= 1'b0;
        fw_config_load <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (start && !abort) begin
              if (bit_count == 16'd0) begin
                err_len <= 1'b1;
              end else begin
                err_len   <= 1'b0;
                bits_left <= bit_count;
                half_q    <= half_eff;
                cap_cnt   <= '0;
                cap_reg   <= '0;
                state     <= FETCH;
              end
            end
          end

          FETCH: begin
            fw_config_clk <= 1'b0;
            if (wr_valid) begin
              shift_reg    <= wr_data;
              fw_config_in <= wr_data[31];
              bit_idx      <= '0;
              timer        <= half_m1;
              state        <= SHIFT_LO;
            end
          end

          SHIFT_LO: begin
            if (timer == '0) begin
              // fw_config_out is sampled on the same edge that raises fw_config_clk.
              fw_config_clk <= 1'b1;
              timer         <= half_m1;
              state         <= SHIFT_HI;
              cap_reg       <= cap_next;
              if (cap_last) begin
                cap_cnt    <= '0;
                pend_valid <= 1'b1;
                pend_full  <= (cnt_next == 6'd32);
                pend_data  <= cap_aligned;
              end else begin
                cap_cnt <= cnt_next;
              end
            end else begin
              timer <= timer - TW'(1);
            end
          end

          SHIFT_HI: begin
            if (timer == '0) begin
              fw_config_clk <= 1'b0;
              bits_left     <= bits_left - 16'd1;
              if (bits_left == 16'd1) begin
                fw_config_in   <= 1'b0;
                fw_config_load <= 1'b0;
                timer          <= load_m1;
                state          <= LOAD;
              end else if (bit_idx == 5'd31) begin
                state <= FETCH;
              end else begin
                shift_reg    <= {shift_reg[30:0], 1'b0};
                fw_config_in <= shift_reg[30];
                bit_idx      <= bit_idx + 5'd1;
                timer        <= half_m1;
                state        <= SHIFT_LO;
              end
            end else begin
              timer <= timer - TW'(1);
            end
          end

          LOAD: begin
            if (timer == '0) begin
              fw_config_load <= 1'b1;
              done           <= 1'b1;
              state          <= DONE;
            end else begin
              timer <= timer - TW'(1);
            end
          end

          DONE: begin
            state <= IDLE;
          end

          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule
